// File: rtl/execute_pkg.sv
// Shared execute-stage types: ALU and multiply/divide operation encodings,
// the multiply/divide FSM states and the operand signedness helpers.
package execute_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_LUI  = 4'b1010
  } alu_operation;

  // Encoded in funct3 order so the decoder can pass funct3 straight through.
  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_operation;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_DONE = 2'b10
  } muldiv_state;

  localparam int          MULDIV_ITER      = 32;
  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h80000000;

  function automatic logic md_is_div(input muldiv_operation op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

  function automatic logic md_a_signed(input muldiv_operation op);
    return op inside {MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic md_b_signed(input muldiv_operation op);
    return op inside {MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Magnitude extraction for incoming operands and sign restoration for the
// unsigned product / quotient / remainder produced by the shared datapath.
module muldiv_signfix #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   i_src_a,
  input  logic [DATA_WIDTH-1:0]   i_src_b,
  input  logic                    i_src_neg_a,
  input  logic                    i_src_neg_b,
  output logic [DATA_WIDTH-1:0]   o_mag_a,
  output logic [DATA_WIDTH-1:0]   o_mag_b,
  input  logic [2*DATA_WIDTH-1:0] i_prod,
  input  logic [DATA_WIDTH-1:0]   i_quot,
  input  logic [DATA_WIDTH-1:0]   i_rem,
  input  logic                    i_res_neg_a,
  input  logic                    i_res_neg_b,
  output logic [2*DATA_WIDTH-1:0] o_prod,
  output logic [DATA_WIDTH-1:0]   o_quot,
  output logic [DATA_WIDTH-1:0]   o_rem
);

  logic w_neg_res;

  assign o_mag_a   = i_src_neg_a ? -i_src_a : i_src_a;
  assign o_mag_b   = i_src_neg_b ? -i_src_b : i_src_b;

  // Sign flags are only ever set for signed operands, so unsigned ops pass through.
  assign w_neg_res = i_res_neg_a ^ i_res_neg_b;
  assign o_prod    = w_neg_res ? -i_prod : i_prod;
  assign o_quot    = w_neg_res ? -i_quot : i_quot;
  assign o_rem     = i_res_neg_a ? -i_rem : i_rem;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and
// restoring divide on operand magnitudes, with a one-cycle divide fast path.
module muldiv_unit
  import execute_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Start,
  input  logic [2:0]            MulDivOp,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic                  Flush,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam int W = DATA_WIDTH;

  muldiv_state     r_state, w_state_nxt;
  muldiv_operation r_op, w_op;
  logic            r_neg_a, r_neg_b;
  logic [W-1:0]    r_a, r_b;
  logic [2*W-1:0]  r_acc, w_acc_nxt;
  logic [4:0]      r_cnt;
  logic [W-1:0]    r_result;

  logic            w_neg_a_in, w_neg_b_in, w_div_zero, w_div_ovf, w_fast;
  logic            w_accept, w_last, w_div, w_ge;
  logic [W-1:0]    w_mag_a, w_mag_b, w_fast_res, w_calc_res, w_quot_fix, w_rem_fix;
  logic [2*W-1:0]  w_prod_fix;
  logic [W:0]      w_rem_sh, w_lhs, w_rhs;
  logic [W+1:0]    w_sum;

  assign w_op       = muldiv_operation'(MulDivOp);
  assign w_neg_a_in = md_a_signed(w_op) & SrcA[W-1];
  assign w_neg_b_in = md_b_signed(w_op) & SrcB[W-1];
  assign w_div_zero = md_is_div(w_op) && (SrcB == '0);
  assign w_div_ovf  = (w_op inside {DIV, REM}) && (SrcA == DIV_OVF_DIVIDEND) && (SrcB == '1);
  assign w_fast     = w_div_zero | w_div_ovf;
  assign w_accept   = (r_state == MD_IDLE) && Start && !Flush;
  assign w_last     = (r_state == MD_CALC) && (r_cnt == 5'(MULDIV_ITER - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= MD_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MD_IDLE: if (Start) w_state_nxt = w_fast ? MD_DONE : MD_CALC;
      MD_CALC: if (w_last) w_state_nxt = MD_DONE;
      default: w_state_nxt = MD_IDLE;
    endcase
    if (Flush) w_state_nxt = MD_IDLE;
  end

  // Output decode
  always_comb begin
    Busy = (r_state != MD_IDLE);
    Done = (r_state == MD_DONE);
  end

  assign Result = r_result;

  // One 34-bit adder serves both ops: add the partial product, or trial-subtract the divisor.
  assign w_div     = md_is_div(r_op);
  assign w_rem_sh  = {r_acc[2*W-1:W], r_a[W-1]};
  assign w_lhs     = w_div ? w_rem_sh : {1'b0, r_acc[2*W-1:W]};
  assign w_rhs     = w_div ? ~{1'b0, r_b} : {1'b0, (r_b[0] ? r_a : '0)};
  assign w_sum     = {1'b0, w_lhs} + {w_div, w_rhs} + {{(W+1){1'b0}}, w_div};
  assign w_ge      = ~w_sum[W+1];
  assign w_acc_nxt = w_div ? {(w_ge ? w_sum[W-1:0] : w_rem_sh[W-1:0]), r_acc[W-2:0], w_ge}
                           : {w_sum[W:0], r_acc[W-1:1]};

  muldiv_signfix #(.DATA_WIDTH(W)) u_signfix (
    .i_src_a     (SrcA),
    .i_src_b     (SrcB),
    .i_src_neg_a (w_neg_a_in),
    .i_src_neg_b (w_neg_b_in),
    .o_mag_a     (w_mag_a),
    .o_mag_b     (w_mag_b),
    .i_prod      (w_acc_nxt),
    .i_quot      (w_acc_nxt[W-1:0]),
    .i_rem       (w_acc_nxt[2*W-1:W]),
    .i_res_neg_a (r_neg_a),
    .i_res_neg_b (r_neg_b),
    .o_prod      (w_prod_fix),
    .o_quot      (w_quot_fix),
    .o_rem       (w_rem_fix)
  );

  always_comb begin
    w_calc_res = w_rem_fix;
    case (r_op)
      MUL:                 w_calc_res = w_prod_fix[W-1:0];
      MULH, MULHSU, MULHU: w_calc_res = w_prod_fix[2*W-1:W];
      DIV, DIVU:           w_calc_res = w_quot_fix;
      default:             w_calc_res = w_rem_fix;
    endcase
  end

  always_comb begin
    w_fast_res = '0;
    if (w_div_zero)                w_fast_res = (w_op inside {DIV, DIVU}) ? '1 : SrcA;
    else if (w_op == DIV)          w_fast_res = DIV_OVF_DIVIDEND;
  end

  // Control and architecturally visible result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
      if (w_fast) r_result <= w_fast_res;
    end else if ((r_state == MD_CALC) && !Flush) begin
      r_cnt <= r_cnt + 5'd1;
      if (w_last) r_result <= w_calc_res;
    end
  end

  // Operand latch and iteration datapath
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op    <= w_op;
      r_neg_a <= w_neg_a_in;
      r_neg_b <= w_neg_b_in;
      r_a     <= w_mag_a;
      r_b     <= w_mag_b;
      r_acc   <= '0;
    end else if (r_state == MD_CALC) begin
      r_acc <= w_acc_nxt;
      if (w_div) r_a <= r_a << 1;
      else       r_b <= r_b >> 1;
    end
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle RV32M multiply/divide unit in the execute stage, beside the ALU. It takes the same forwarded SrcA/SrcB operands and produces a result that the EX/MEM input mux selects in place of ALUResult. The hazard unit uses Busy to stall the pipeline until Done. It executes all eight M-extension operations with one shared shift/add datapath.

## Interface
Parameters:
- DATA_WIDTH, 32, operand and result width

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- Start  in  1  request; sampled only in IDLE
- MulDivOp  in  3  muldiv_operation: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- SrcA  in  DATA_WIDTH  rs1 operand (multiplicand / dividend)
- SrcB  in  DATA_WIDTH  rs2 operand (multiplier / divisor)
- Flush  in  1  abort the in-flight operation (branch mispredict / trap)
- Busy  out  1  operation in progress; high from accept+1 through the Done cycle
- Done  out  1  one-cycle pulse; Result valid this cycle
- Result  out  DATA_WIDTH  final result; held until the next accepted Start

## Operation
- States: IDLE, CALC, DONE.
- IDLE -> CALC when Start=1 and Flush=0.
  - Latch op, sign flags and |SrcA|, |SrcB|.
  - Absolute value is applied only to operands that are signed for the op: MULH both, MULHSU SrcA only, DIV/REM both.
  - Clear the 64-bit accumulator and the 5-bit counter.
- IDLE -> DONE directly (fast path) in two cases:
  - Divide by zero, DIV/DIVU/REM/REMU with SrcB==0.
  - Signed overflow, DIV/REM with SrcA==0x80000000 and SrcB==0xFFFFFFFF.
- CALC runs one iteration per cycle for 32 cycles; counter 0..31, -> DONE when counter==31.
  - Multiply: radix-2 shift-add; 64-bit unsigned product of the magnitudes.
  - Divide: restoring; 32-bit quotient and 32-bit remainder of the magnitudes.
- On the CALC->DONE edge, the sign fix-up is applied and Result is registered:
  - MUL takes the low 32 bits; MULH/MULHSU/MULHU take the high 32 bits.
  - The product is negated (64-bit two's complement) when the operand signs differ, for the signed ops only.
  - The quotient is negated if the dividend and divisor signs differ.
  - The remainder takes the sign of the dividend.
- Fast-path results:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = SrcA.
  - Signed overflow: quotient 0x80000000, remainder 0.
- DONE -> IDLE unconditionally. Done=1 in DONE only.
- Start in CALC or DONE is ignored; the hazard unit holds the instruction in EX while Busy=1.
- Flush=1 in any state -> IDLE on the next edge.
  - Done is suppressed and Result is unchanged.
  - Flush wins over a simultaneous Start.
- All arithmetic is modulo 2^DATA_WIDTH. There is no exception output.

## Timing
- Reset (rst_n=0 at an edge):
  - State IDLE, Busy=0, Done=0, Result=0, counter=0.
  - Reset in the middle of an operation discards it and produces no Done.
- Start accepted at edge N:
  - Busy=1 in cycles N+1..N+33.
  - Done=1 and Result valid in cycle N+33 (33-cycle latency).
  - Back in IDLE at N+34, so a new Start can be accepted in cycle N+34.
- Fast path: Done=1 and Busy=1 in cycle N+1; IDLE at N+2.
- Done is never high for two consecutive cycles.
- Flush at edge M during CALC: Busy=0 from M+1 onward.
- Outputs are registered. There is no combinational path from SrcA/SrcB to Result.

## Structure
- Shared package execute_pkg holds two enums:
  - the alu_operation enum, moved out of the ALU file;
  - the new muldiv_operation enum (MUL=3'b000 … REMU=3'b111, funct3 order).
- The package also holds the constants MULDIV_ITER=32 and DIV_OVF_DIVIDEND=32'h80000000.
- There is one natural sub-module, muldiv_signfix: combinational magnitude/negate helpers used at operand latch and at result write-back.
- The FSM and datapath stay in muldiv_unit.

## Test plan
- MUL SrcA=7, SrcB=0xFFFFFFFD (-3): Start at edge N -> Done at N+33, Result=0xFFFFFFEB; Busy low at N+34.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> Result=0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF. MULH same operands -> 0x00000000.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Divide by zero:
  - DIVU 5/0 -> 0xFFFFFFFF with Done at N+1.
  - REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; both with Done at N+1.
- Start MUL, Flush at cycle N+10 -> no Done pulse ever, Busy=0 from N+11, Result keeps its prior value; a Start at N+11 is accepted, with Done at N+44.
- Control corner cases:
  - Start pulsed during CALC -> ignored, exactly one Done.
  - rst_n=0 at N+5 -> all outputs 0 at N+6, no Done.
  - Flush and Start together in IDLE -> stays IDLE.
